decoder_3to8_pipe: RTL and testbench

- Registered 3-to-8 one-hot decoder. It is the receive-side counterpart of the 8:3 encoder: it turns a binary code back into a one-hot lane select.
- The input and output use valid/ready handshakes, with a 2-entry output buffer to absorb downstream backpressure.
- A built-in sweep sequencer walks codes 0..7 so downstream one-hot consumers can self-test.
- Sits between the code source (encoder or control logic) and one-hot consumers such as lane muxes and enables.

---
 rtl/decoder_3to8_pipe.sv | 141 ++++++++++++++
 tb/tb_decoder_3to8_pipe.sv | 436 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/decoder_3to8_pipe.sv
// Registered 3-to-8 one-hot decoder with valid/ready handshakes, a 2-entry
// output buffer (output register + skid) and a built-in 0..7 sweep sequencer.
module decoder_3to8_pipe #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [2:0]       in_code,
   input  logic             in_en,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [7:0]       out_onehot,
   input  logic             sweep_start,
   output logic             sweep_busy,
   output logic             sweep_done,
   output logic [CNT_W-1:0] accept_count
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_SWEEP,
      S_DONE
   } state_t;

   state_t             r_state;
   state_t             w_state_next;
   logic [2:0]         r_idx;

   logic               r_out_valid;
   logic [7:0]         r_out_word;
   logic               r_skid_valid;
   logic [7:0]         r_skid_word;
   logic [CNT_W-1:0]   r_count;

   logic               w_idle;
   logic               w_space;
   logic               w_ext_push;
   logic               w_sweep_push;
   logic               w_push;
   logic               w_pop;
   logic [7:0]         w_ext_word;
   logic [7:0]         w_push_word;

   // Space means the skid slot is free; out_ready is deliberately not used so
   // in_ready never depends combinationally on the downstream.
   assign w_space      = !r_skid_valid;
   assign in_ready     = rst_n && w_idle && w_space;

   assign w_ext_word   = in_en ? (8'h01 << in_code) : 8'h00;
   assign w_ext_push   = in_valid && in_ready;
   assign w_sweep_push = (r_state == S_SWEEP) && w_space;
   assign w_push       = w_ext_push || w_sweep_push;
   assign w_push_word  = w_sweep_push ? (8'h01 << r_idx) : w_ext_word;
   assign w_pop        = r_out_valid && out_ready;

   // NOTE: sequential state uses <= so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
         r_idx   <= '0;
      end else begin
         r_state <= w_state_next;
         if (r_state != S_SWEEP) begin
            r_idx <= '0;
         end else if (w_sweep_push) begin
            r_idx <= r_idx + 3'd1;
         end
      end
   end

   // NOTE: defaulting the comb target first keeps every path assigned (no latch).
   always_comb begin
      w_state_next = r_state;
      unique case (r_state)
         S_IDLE:  if (sweep_start) w_state_next = S_SWEEP;
         S_SWEEP: if (w_sweep_push && (r_idx == 3'd7)) w_state_next = S_DONE;
         S_DONE:  w_state_next = S_IDLE;
         default: w_state_next = S_IDLE;
      endcase
   end

   always_comb begin
      w_idle     = 1'b0;
      sweep_busy = 1'b0;
      sweep_done = 1'b0;
      unique case (r_state)
         S_IDLE:  w_idle     = 1'b1;
         S_SWEEP: sweep_busy = 1'b1;
         S_DONE:  sweep_done = 1'b1;
         default: w_idle     = 1'b0;
      endcase
   end

   // Two-entry FIFO: a push while the skid is occupied is impossible, so a pop
   // with a full skid only has to promote the skid word.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_out_valid  <= 1'b0;
         r_out_word   <= 8'h00;
         r_skid_valid <= 1'b0;
      end else if (w_pop) begin
         if (r_skid_valid) begin
            r_out_word   <= r_skid_word;
            r_skid_valid <= 1'b0;
         end else if (w_push) begin
            r_out_word <= w_push_word;
         end else begin
            r_out_valid <= 1'b0;
         end
      end else if (w_push) begin
         if (!r_out_valid) begin
            r_out_valid <= 1'b1;
            r_out_word  <= w_push_word;
         end else begin
            r_skid_valid <= 1'b1;
         end
      end
   end

   // NOTE: skid data needs no reset; r_skid_valid alone qualifies it.
   always_ff @(posedge clk) begin
      if (w_push && !w_pop && r_out_valid) begin
         r_skid_word <= w_push_word;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_count <= '0;
      end else if (w_pop) begin
         r_count <= r_count + CNT_W'(1);
      end
   end

   assign out_valid    = r_out_valid;
   assign out_onehot   = r_out_word;
   assign accept_count = r_count;

endmodule

// File: tb/tb_decoder_3to8_pipe.sv
// Self-checking bench for decoder_3to8_pipe: directed scenarios plus random
// traffic, all checked against a queue-based cycle model of the block.
module tb_decoder_3to8_pipe;

   localparam int CNT_W = 4;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             in_valid = 1'b0;
   logic             in_ready;
   logic [2:0]       in_code = 3'd0;
   logic             in_en = 1'b0;
   logic             out_valid;
   logic             out_ready = 1'b0;
   logic [7:0]       out_onehot;
   logic             sweep_start = 1'b0;
   logic             sweep_busy;
   logic             sweep_done;
   logic [CNT_W-1:0] accept_count;

   always #5 clk = ~clk;

   decoder_3to8_pipe #(.CNT_W(CNT_W)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .in_code      (in_code),
      .in_en        (in_en),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .out_onehot   (out_onehot),
      .sweep_start  (sweep_start),
      .sweep_busy   (sweep_busy),
      .sweep_done   (sweep_done),
      .accept_count (accept_count)
   );

   int n_assert = 0;
   int n_fail   = 0;

   // Reference model: the buffer is a queue of words, the sequencer a mode
   // number (0 idle, 1 sweep, 2 done) with the next sweep index.
   logic [7:0] q[$];
   logic [7:0] obs[$];
   int         pop_cyc[$];
   int         cyc_no    = 0;
   int         done_seen = 0;
   int         mode      = 0;
   int         sidx      = 0;
   int         cnt       = 0;
   logic [7:0] last      = 8'h00;

   always @(negedge clk) begin : monitor
      logic       exp_ir;
      logic       exp_ov;
      logic [7:0] exp_word;
      logic       pop;
      logic       push;
      logic [7:0] pw;
      cyc_no++;
      exp_ir   = rst_n && (mode == 0) && (q.size() < 2);
      exp_ov   = (q.size() > 0);
      exp_word = exp_ov ? q[0] : last;

      n_assert++;
      if (in_ready !== exp_ir) begin
         n_fail++;
         $display("FAIL in_ready: got %b expected %b (cycle %0d)", in_ready, exp_ir, cyc_no);
      end
      n_assert++;
      if (out_valid !== exp_ov) begin
         n_fail++;
         $display("FAIL out_valid: got %b expected %b (cycle %0d)", out_valid, exp_ov, cyc_no);
      end
      n_assert++;
      if (out_onehot !== exp_word) begin
         n_fail++;
         $display("FAIL out_onehot: got %h expected %h (cycle %0d)", out_onehot, exp_word, cyc_no);
      end
      n_assert++;
      if (sweep_busy !== (mode == 1)) begin
         n_fail++;
         $display("FAIL sweep_busy: got %b expected %b (cycle %0d)", sweep_busy, (mode == 1), cyc_no);
      end
      n_assert++;
      if (sweep_done !== (mode == 2)) begin
         n_fail++;
         $display("FAIL sweep_done: got %b expected %b (cycle %0d)", sweep_done, (mode == 2), cyc_no);
      end
      n_assert++;
      if (accept_count !== CNT_W'(cnt)) begin
         n_fail++;
         $display("FAIL accept_count: got %0d expected %0d (cycle %0d)", accept_count, cnt, cyc_no);
      end
      if (sweep_done === 1'b1) done_seen++;

      // Predict the coming rising edge.
      if (!rst_n) begin
         q.delete();
         mode = 0;
         sidx = 0;
         cnt  = 0;
         last = 8'h00;
      end else begin
         pop  = exp_ov && out_ready;
         push = 1'b0;
         pw   = 8'h00;
         if (mode == 0 && in_valid && exp_ir) begin
            push = 1'b1;
            pw   = in_en ? 8'(1 << in_code) : 8'h00;
         end else if (mode == 1 && q.size() < 2) begin
            push = 1'b1;
            pw   = 8'(1 << sidx);
         end
         if (pop) begin
            obs.push_back(q[0]);
            pop_cyc.push_back(cyc_no);
            void'(q.pop_front());
            cnt = (cnt + 1) % (1 << CNT_W);
         end
         if (push) q.push_back(pw);
         case (mode)
            0: if (sweep_start) begin mode = 1; sidx = 0; end
            1: if (push) begin if (sidx == 7) mode = 2; sidx++; end
            default: mode = 0;
         endcase
         if (q.size() > 0) last = q[0];
      end
   end

   // Drive just after the rising edge; inspect just after the monitor ran.
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      @(negedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      cyc();
      cyc();
      settle();
      n_assert++;
      if (out_valid !== 1'b0 || out_onehot !== 8'h00 || in_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_outputs: got valid=%b word=%h ready=%b expected 0/00/0", out_valid, out_onehot, in_ready);
      end
      n_assert++;
      if (sweep_busy !== 1'b0 || sweep_done !== 1'b0 || accept_count !== '0) begin
         n_fail++;
         $display("FAIL reset_sweep_count: got busy=%b done=%b count=%0d expected 0/0/0", sweep_busy, sweep_done, accept_count);
      end
      cyc();
      rst_n = 1'b1;
      settle();
      n_assert++;
      if (in_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL ready_after_reset: got %b expected 1", in_ready);
      end
   endtask

   task automatic test_decode();
      obs.delete();
      cyc();
      out_ready = 1'b1;
      in_valid  = 1'b1;
      in_en     = 1'b1;
      in_code   = 3'd5;
      cyc();
      in_code = 3'd3;
      settle();
      n_assert++;
      if (out_valid !== 1'b1 || out_onehot !== 8'b0010_0000) begin
         n_fail++;
         $display("FAIL decode_5: got valid=%b word=%b expected 1/00100000", out_valid, out_onehot);
      end
      cyc();
      in_valid = 1'b0;
      settle();
      n_assert++;
      if (out_valid !== 1'b1 || out_onehot !== 8'b0000_1000) begin
         n_fail++;
         $display("FAIL decode_3: got valid=%b word=%b expected 1/00001000", out_valid, out_onehot);
      end
      cyc();
      settle();
      n_assert++;
      if (accept_count !== CNT_W'(2) || out_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL decode_count: got count=%0d valid=%b expected 2/0", accept_count, out_valid);
      end
   endtask

   task automatic test_disable();
      cyc();
      in_valid = 1'b1;
      in_en    = 1'b0;
      in_code  = 3'd6;
      cyc();
      in_valid = 1'b0;
      settle();
      n_assert++;
      if (out_valid !== 1'b1 || out_onehot !== 8'h00) begin
         n_fail++;
         $display("FAIL disable_word: got valid=%b word=%h expected 1/00", out_valid, out_onehot);
      end
      cyc();
      settle();
      n_assert++;
      if (accept_count !== CNT_W'(3)) begin
         n_fail++;
         $display("FAIL disable_count: got %0d expected 3", accept_count);
      end
   endtask

   task automatic test_backpressure();
      bit got = 1'b0;
      obs.delete();
      cyc();
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_en     = 1'b1;
      in_code   = 3'd1;
      settle();
      n_assert++;
      if (in_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL bp_accept_1: got ready=%b expected 1", in_ready);
      end
      cyc();
      in_code = 3'd2;
      settle();
      n_assert++;
      if (in_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL bp_accept_2: got ready=%b expected 1", in_ready);
      end
      cyc();
      in_code = 3'd4;
      cyc();
      settle();
      n_assert++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_onehot !== 8'h02) begin
         n_fail++;
         $display("FAIL bp_stall: got ready=%b valid=%b word=%h expected 0/1/02", in_ready, out_valid, out_onehot);
      end
      cyc();
      out_ready = 1'b1;
      for (int i = 0; i < 10; i++) begin
         settle();
         if (in_ready === 1'b1) begin
            got = 1'b1;
            break;
         end
         cyc();
      end
      cyc();
      in_valid = 1'b0;
      n_assert++;
      if (!got) begin
         n_fail++;
         $display("FAIL bp_release: got ready=0 for 10 cycles expected 1");
      end
      repeat (4) cyc();
      settle();
      n_assert++;
      if (obs.size() != 3 || obs[0] !== 8'h02 || obs[1] !== 8'h04 || obs[2] !== 8'h10) begin
         n_fail++;
         $display("FAIL bp_order: got %p expected '{02,04,10}", obs);
      end
   endtask

   task automatic test_sweep(input bit toggle);
      obs.delete();
      pop_cyc.delete();
      done_seen = 0;
      cyc();
      out_ready   = 1'b1;
      sweep_start = 1'b1;
      cyc();
      sweep_start = 1'b0;
      settle();
      n_assert++;
      if (sweep_busy !== 1'b1 || in_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL sweep_enter: got busy=%b ready=%b expected 1/0", sweep_busy, in_ready);
      end
      for (int i = 0; i < 60 && obs.size() < 8; i++) begin
         cyc();
         if (toggle) out_ready = ~out_ready;
         settle();
      end
      cyc();
      out_ready = 1'b1;
      repeat (3) cyc();
      settle();
      n_assert++;
      if (obs.size() != 8) begin
         n_fail++;
         $display("FAIL sweep_count: got %0d words expected 8", obs.size());
      end else begin
         for (int i = 0; i < 8; i++) begin
            n_assert++;
            if (obs[i] !== 8'(1 << i)) begin
               n_fail++;
               $display("FAIL sweep_word%0d: got %h expected %h", i, obs[i], 8'(1 << i));
            end
         end
         if (!toggle) begin
            n_assert++;
            if (pop_cyc[7] - pop_cyc[0] != 7) begin
               n_fail++;
               $display("FAIL sweep_rate: got span %0d cycles expected 7", pop_cyc[7] - pop_cyc[0]);
            end
         end
      end
      n_assert++;
      if (done_seen != 1) begin
         n_fail++;
         $display("FAIL sweep_done_pulse: got %0d cycles expected 1", done_seen);
      end
      n_assert++;
      if (in_ready !== 1'b1 || sweep_busy !== 1'b0) begin
         n_fail++;
         $display("FAIL sweep_exit: got ready=%b busy=%b expected 1/0", in_ready, sweep_busy);
      end
   endtask

   task automatic test_wrap();
      int n_acc = 0;
      cyc();
      rst_n = 1'b0;
      cyc();
      rst_n     = 1'b1;
      out_ready = 1'b1;
      in_valid  = 1'b1;
      in_en     = 1'b1;
      in_code   = 3'($urandom_range(7));
      obs.delete();
      for (int i = 0; i < 60 && n_acc < 17; i++) begin
         settle();
         if (in_ready === 1'b1) n_acc++;
         cyc();
         in_code = 3'($urandom_range(7));
         if (n_acc == 17) in_valid = 1'b0;
      end
      in_valid = 1'b0;
      repeat (3) cyc();
      settle();
      n_assert++;
      if (obs.size() != 17 || accept_count !== CNT_W'(1)) begin
         n_fail++;
         $display("FAIL wrap: got %0d words count=%0d expected 17/1", obs.size(), accept_count);
      end
   endtask

   task automatic test_reset_mid_sweep();
      obs.delete();
      cyc();
      out_ready   = 1'b1;
      sweep_start = 1'b1;
      cyc();
      sweep_start = 1'b0;
      for (int i = 0; i < 40; i++) begin
         settle();
         if (obs.size() >= 3) break;
         cyc();
      end
      cyc();
      out_ready = 1'b0;
      repeat (2) cyc();
      rst_n = 1'b0;
      cyc();
      settle();
      n_assert++;
      if (out_valid !== 1'b0 || sweep_busy !== 1'b0 || accept_count !== '0) begin
         n_fail++;
         $display("FAIL mid_sweep_reset: got valid=%b busy=%b count=%0d expected 0/0/0", out_valid, sweep_busy, accept_count);
      end
      cyc();
      rst_n     = 1'b1;
      out_ready = 1'b1;
      repeat (20) cyc();
      settle();
      n_assert++;
      if (obs.size() != 3 || out_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL mid_sweep_flush: got %0d words valid=%b expected 3/0", obs.size(), out_valid);
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 2000; i++) begin
         cyc();
         in_valid    = 1'($urandom_range(1));
         in_code     = 3'($urandom_range(7));
         in_en       = ($urandom_range(7) != 0);
         out_ready   = ($urandom_range(3) != 0);
         sweep_start = ($urandom_range(59) == 0);
         rst_n       = ($urandom_range(399) != 0);
      end
      cyc();
      rst_n       = 1'b1;
      in_valid    = 1'b0;
      sweep_start = 1'b0;
      out_ready   = 1'b1;
      repeat (30) cyc();
      settle();
      n_assert++;
      if (out_valid !== 1'b0 || sweep_busy !== 1'b0) begin
         n_fail++;
         $display("FAIL random_drain: got valid=%b busy=%b expected 0/0", out_valid, sweep_busy);
      end
   endtask

   initial begin
      test_reset();
      test_decode();
      test_disable();
      test_backpressure();
      test_sweep(1'b0);
      test_sweep(1'b1);
      test_wrap();
      test_reset_mid_sweep();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
